unified_mem_ctrl: RTL and testbench
===================================

// Module: unified_mem_ctrl
// PURPOSE
//  Next-generation von Neumann memory: one shared array serving an instruction-fetch port and a data port.
//  Adds registered (1-cycle) reads, a programmable data-segment base, wrap-fault detection and a
//  post-reset clear sequencer. Sits between the fetch stage and the MEM stage of the pipeline.
// PARAMETERS
//  DATA_W        8    word width, bits
//  ADDR_W        8    address width; array depth = 2**ADDR_W
//  DBASE_RST     128  data-segment base loaded on reset
//  CLEAR_ON_RST  1    1: zero the whole array after reset; 0: skip clearing
// PORTS
//  clk         in   1       single clock, rising edge
//  rst         in   1       asynchronous, active-high reset
//  i_req       in   1       instruction fetch request
//  i_addr      in   ADDR_W  absolute instruction address
//  i_valid     out  1       i_data valid (one cycle after i_req)
//  i_data      out  DATA_W  fetched instruction word
//  d_req       in   1       data access request
//  d_we        in   1       1 = write, 0 = read (qualified by d_req)
//  d_addr      in   ADDR_W  segment-relative data address
//  d_wdata     in   DATA_W  write data
//  d_valid     out  1       data response valid (one cycle after d_req)
//  d_rdata     out  DATA_W  read data, or written data on a write
//  d_fault     out  1       segment wrap fault, qualified by d_valid
//  base_we     in   1       load new data-segment base
//  base_wdata  in   ADDR_W  new base value
//  base        out  ADDR_W  current data-segment base
//  busy        out  1       clear sequence active; all requests ignored
// BEHAVIOUR
//  Reset: base=DBASE_RST; i_valid=d_valid=d_fault=0; i_data=d_rdata=0; clr_cnt=0;
//   busy=CLEAR_ON_RST; state=INIT if CLEAR_ON_RST else RUN. Array contents are not reset directly.
//  FSM INIT: write 0 to mem[clr_cnt] each cycle, clr_cnt++. Go to RUN after the write to 2**ADDR_W-1
//   (exactly 2**ADDR_W cycles). busy=1 throughout INIT. i_req, d_req and base_we are ignored.
//   No valid pulses are generated.
//  FSM RUN: busy=0. No exit except by reset.
//  Effective address: {c,ea} = d_addr + base, computed at ADDR_W+1 bits. c=1 is a fault (wrap past the top).
//  Fetch: i_req at edge N -> i_valid=1 and i_data=mem[i_addr] after edge N+1. i_valid is a 1-cycle pulse per request.
//  Data read: d_req & !d_we -> next cycle d_valid=1, d_rdata=mem[ea], d_fault=0.
//  Data write: d_req & d_we -> mem[ea]<=d_wdata at the edge. Next cycle d_valid=1, d_rdata=d_wdata.
//  Fault (c=1): write suppressed, d_rdata=0, d_fault=1 with d_valid. d_fault is 0 whenever d_valid=0.
//  Collision: write to ea and fetch of i_addr==ea in the same cycle -> i_data returns the new d_wdata (write-first).
//  base_we: base<=base_wdata at the edge. A data access in the same cycle uses the old base.
//  i_data/d_rdata hold their last value when valid=0.
//  Reset mid-operation: asynchronously aborts INIT or RUN and restarts at INIT with clr_cnt=0.
//   In-flight responses are dropped; valids deassert immediately.
//  Both ports may be accepted in the same cycle; there is no stall and no backpressure in RUN.
// STRUCTURE
//  Shared package mem_pkg: DATA_W/ADDR_W defaults, DBASE_RST, state encoding {ST_INIT, ST_RUN}.
//  Sub-module mem_array: 2**ADDR_W x DATA_W, one write port, two synchronous read ports, write-first bypass.
//  Top level holds the FSM, clear counter, base register, fault logic and response registers.
// TESTING
//  1 Reset, CLEAR_ON_RST=1, ADDR_W=8 -> busy=1 for 256 cycles. Then i_req to every address returns 0x00.
//  2 Write d_addr=0x05 data 0xA5 (base=128) -> d_valid, d_rdata=0xA5. Fetch i_addr=0x85 -> i_data=0xA5.
//  3 base_we=1 with 0x40, same-cycle read d_addr=0x01 -> result uses old base (mem[0x81]).
//   Next read d_addr=0x01 -> mem[0x41].
//  4 Write d_addr=0x90 with base=0x80 -> d_fault=1, d_rdata=0, mem[0x10] unchanged.
//  5 Same-cycle write ea=0x88 data 0x3C plus fetch i_addr=0x88 -> i_data=0x3C, d_rdata=0x3C.
//  6 Assert rst mid-INIT at clr_cnt=100 -> busy stays 1, a full 256-cycle clear restarts, base=128.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the unified instruction/data memory controller.
package mem_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int ADDR_W_DEF    = 8;
  localparam int DBASE_RST_DEF = 128;

  // Read ports on the shared array: lane 0 serves fetch, lane 1 serves data.
  localparam int NUM_RD = 2;
  localparam int RD_I   = 0;
  localparam int RD_D   = 1;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

endpackage

// File: rtl/unified_mem_ctrl_if.sv
// Fetch port, data port and base-register bus of the unified memory controller.
interface unified_mem_ctrl_if import mem_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_valid;
  logic [DATA_W-1:0] i_data;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_valid;
  logic [DATA_W-1:0] d_rdata;
  logic              d_fault;
  logic              base_we;
  logic [ADDR_W-1:0] base_wdata;
  logic [ADDR_W-1:0] base;
  logic              busy;

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, base_we, base_wdata,
    input  i_valid, i_data, d_valid, d_rdata, d_fault, base, busy
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, base_we, base_wdata,
    output i_valid, i_data, d_valid, d_rdata, d_fault, base, busy
  );
endinterface

// File: rtl/mem_array.sv
// Shared storage: one write port, NUM_RD registered read ports, write-first bypass.
module mem_array import mem_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int N_RD   = NUM_RD
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic [ADDR_W-1:0]            waddr,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [N_RD-1:0]              re,
  input  logic [N_RD-1:0][ADDR_W-1:0]  raddr,
  output logic [N_RD-1:0][DATA_W-1:0]  rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Array write; contents are deliberately not reset (the controller clears them).
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  for (genvar g = 0; g < N_RD; g++) begin : g_rd
    logic [DATA_W-1:0] q;

    // Read register only moves on an enabled read so data holds between requests.
    always_ff @(posedge clk or posedge rst)
      if (rst)        q <= '0;
      else if (re[g]) q <= (we && waddr == raddr[g]) ? wdata : mem[raddr[g]];

    assign rdata[g] = q;
  end

endmodule

// File: rtl/unified_mem_ctrl.sv
// Unified von Neumann memory: fetch + data ports on one array, segment base,
// wrap-fault detection and a post-reset clear sequencer.
module unified_mem_ctrl import mem_pkg::*; #(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DBASE_RST    = DBASE_RST_DEF,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input logic               clk,
  input logic               rst,
  unified_mem_ctrl_if.slave bus
);

  localparam logic [ADDR_W-1:0] CLR_LAST = '1;

  state_e            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] base_q;
  logic              busy_q;
  logic              i_vld_q;
  logic              d_vld_q;
  logic              fault_q;

  logic [ADDR_W:0]   sum;
  logic              wrap;
  logic [ADDR_W-1:0] ea;
  logic              init;
  logic              i_acc;
  logic              d_acc;

  logic                          m_we;
  logic [ADDR_W-1:0]             m_waddr;
  logic [DATA_W-1:0]             m_wdata;
  logic [NUM_RD-1:0]             m_re;
  logic [NUM_RD-1:0][ADDR_W-1:0] m_raddr;
  logic [NUM_RD-1:0][DATA_W-1:0] m_rdata;

  // Effective address with carry out: carry means the access wrapped past the top.
  assign sum  = {1'b0, bus.d_addr} + {1'b0, base_q};
  assign wrap = sum[ADDR_W];
  assign ea   = sum[ADDR_W-1:0];

  assign init  = (state == ST_INIT);
  assign i_acc = !init && bus.i_req;
  assign d_acc = !init && bus.d_req;

  // The clear sequencer owns the write port during INIT; faulting writes are dropped.
  assign m_we    = init || (d_acc && bus.d_we && !wrap);
  assign m_waddr = init ? clr_cnt : ea;
  assign m_wdata = init ? '0 : bus.d_wdata;

  // A write also "reads" ea so the bypass returns the written data as d_rdata.
  assign m_re[RD_I]    = i_acc;
  assign m_re[RD_D]    = d_acc && !wrap;
  assign m_raddr[RD_I] = bus.i_addr;
  assign m_raddr[RD_D] = ea;

  mem_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_RD(NUM_RD)) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (m_we),
    .waddr (m_waddr),
    .wdata (m_wdata),
    .re    (m_re),
    .raddr (m_raddr),
    .rdata (m_rdata)
  );

  // FSM, clear counter, base register and response flags.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= CLEAR_ON_RST ? ST_INIT : ST_RUN;
      busy_q  <= CLEAR_ON_RST;
      clr_cnt <= '0;
      base_q  <= ADDR_W'(DBASE_RST);
      i_vld_q <= 1'b0;
      d_vld_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          i_vld_q <= 1'b0;
          d_vld_q <= 1'b0;
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == CLR_LAST) begin
            state  <= ST_RUN;
            busy_q <= 1'b0;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          i_vld_q <= i_acc;
          d_vld_q <= d_acc;
          if (d_acc) fault_q <= wrap;
          if (bus.base_we) base_q <= bus.base_wdata;
        end
      endcase
    end

  assign bus.i_valid = i_vld_q;
  assign bus.i_data  = m_rdata[RD_I];
  assign bus.d_valid = d_vld_q;
  assign bus.d_rdata = fault_q ? '0 : m_rdata[RD_D];
  assign bus.d_fault = d_vld_q && fault_q;
  assign bus.base    = base_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_unified_mem_ctrl.sv
// Directed bench for unified_mem_ctrl (DATA_W=8, ADDR_W=8, base reset 0x80, clear on reset).
`timescale 1ns/1ps
module tb_unified_mem_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  unified_mem_ctrl_if #(.DATA_W(8), .ADDR_W(8)) bus ();

  unified_mem_ctrl #(.DATA_W(8), .ADDR_W(8), .DBASE_RST(128), .CLEAR_ON_RST(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.i_req = 0; bus.d_req = 0; bus.d_we = 0; bus.base_we = 0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Hold busy-count from the moment reset is released until busy drops.
  task automatic count_busy(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 1000) begin
      n++;
      step();
    end
  endtask

  initial begin
    int n;
    int bad;
    bus.i_addr = '0; bus.d_addr = '0; bus.d_wdata = '0; bus.base_wdata = '0;
    idle();

    // Reset state
    step(); step();
    chk("rst_busy",    bus.busy,    1);
    chk("rst_base",    bus.base,    8'h80);
    chk("rst_i_valid", bus.i_valid, 0);
    chk("rst_d_valid", bus.d_valid, 0);
    chk("rst_d_fault", bus.d_fault, 0);
    chk("rst_i_data",  bus.i_data,  0);
    chk("rst_d_rdata", bus.d_rdata, 0);

    // Test 1: 256-cycle clear, then every address fetches zero
    rst = 0;
    count_busy(n);
    chk("clear_cycles", n, 256);
    bad = 0;
    for (int a = 0; a < 256; a++) begin
      bus.i_req = 1; bus.i_addr = 8'(a);
      step();
      bus.i_req = 0;
      if (bus.i_valid !== 1'b1 || bus.i_data !== 8'h00) bad++;
    end
    chk("clear_all_zero", bad, 0);

    // Test 2: write d_addr 0x05 -> mem[0x85], then fetch it
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 8'h05; bus.d_wdata = 8'hA5;
    step(); idle();
    chk("wr_d_valid", bus.d_valid, 1);
    chk("wr_d_rdata", bus.d_rdata, 8'hA5);
    chk("wr_d_fault", bus.d_fault, 0);
    bus.i_req = 1; bus.i_addr = 8'h85;
    step(); idle();
    chk("fetch85_valid", bus.i_valid, 1);
    chk("fetch85_data",  bus.i_data,  8'hA5);
    chk("d_valid_pulse", bus.d_valid, 0);
    step();
    chk("i_valid_pulse", bus.i_valid, 0);
    chk("i_data_hold",   bus.i_data,  8'hA5);
    chk("d_rdata_hold",  bus.d_rdata, 8'hA5);

    // Test 3: base change with same-cycle read uses old base
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 8'h01; bus.d_wdata = 8'h11;   // mem[0x81]=0x11
    step(); idle();
    bus.base_we = 1; bus.base_wdata = 8'h40;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 8'h01;
    step(); idle();
    chk("oldbase_rd",   bus.d_rdata, 8'h11);
    chk("oldbase_vld",  bus.d_valid, 1);
    chk("base_loaded",  bus.base,    8'h40);
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 8'h01;                        // mem[0x41]
    step(); idle();
    chk("newbase_rd",   bus.d_rdata, 8'h00);
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 8'h01; bus.d_wdata = 8'h77;   // mem[0x41]=0x77
    step(); idle();
    bus.i_req = 1; bus.i_addr = 8'h41;
    step(); idle();
    chk("fetch41", bus.i_data, 8'h77);

    // Test 4: wrap fault with base 0x80, write suppressed
    bus.base_we = 1; bus.base_wdata = 8'h80;
    step(); idle();
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 8'h90; bus.d_wdata = 8'hEE;
    step(); idle();
    chk("fault_valid", bus.d_valid, 1);
    chk("fault_flag",  bus.d_fault, 1);
    chk("fault_rdata", bus.d_rdata, 8'h00);
    bus.i_req = 1; bus.i_addr = 8'h10;
    step(); idle();
    chk("fault_nowrite", bus.i_data,  8'h00);
    chk("fault_qual",    bus.d_fault, 0);

    // Test 5: write/fetch collision at ea 0x88 is write-first
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 8'h08; bus.d_wdata = 8'h3C;
    bus.i_req = 1; bus.i_addr = 8'h88;
    step(); idle();
    chk("coll_i_valid", bus.i_valid, 1);
    chk("coll_i_data",  bus.i_data,  8'h3C);
    chk("coll_d_rdata", bus.d_rdata, 8'h3C);
    chk("coll_d_fault", bus.d_fault, 0);

    // Test 6: reset mid-run drops valids at once, then reset again mid-INIT
    bus.i_req = 1; bus.i_addr = 8'h85; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 8'h05;
    @(posedge clk); #1;
    rst = 1; #1;
    chk("async_i_valid", bus.i_valid, 0);
    chk("async_d_valid", bus.d_valid, 0);
    chk("async_busy",    bus.busy,    1);
    step();
    rst = 0;
    // Requests and base writes held during INIT must be ignored
    bus.base_we = 1; bus.base_wdata = 8'h22;
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      step();
      if (bus.i_valid !== 1'b0 || bus.d_valid !== 1'b0 || bus.busy !== 1'b1) bad++;
    end
    chk("init_ignores", bad, 0);
    chk("init_base",    bus.base, 8'h80);
    idle();
    rst = 1;
    step();
    rst = 0;
    count_busy(n);
    chk("reclear_cycles", n, 256);
    chk("reclear_base",   bus.base, 8'h80);
    bus.i_req = 1; bus.i_addr = 8'h85;
    step(); idle();
    chk("reclear_85", bus.i_data, 8'h00);
    bus.i_req = 1; bus.i_addr = 8'h88;
    step(); idle();
    chk("reclear_88", bus.i_data, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
